eth_frame_tx: RTL and testbench

- Serial Ethernet frame transmitter; sits directly upstream of the frame receiver/checker.
- Takes header fields and a byte stream of payload, then emits one bit per clock: preamble, SFD, destination MAC, source MAC, length, payload and a CRC-32 FCS.
- The bitstream it produces is exactly what the downstream receiver parses on its `signal` input.

---
 rtl/eth_frame_tx_if.sv | 41 ++++
 rtl/eth_frame_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_tx_if.sv
// eth_frame_tx_if: frame request, payload byte stream and serial output bundle
// for eth_frame_tx.
//
//   start        frame request (sampled only while the transmitter is idle)
//   dest_mac     destination MAC, latched on an accepted start
//   src_mac      source MAC, latched on an accepted start
//   length       payload byte count, latched on an accepted start
//   din          payload byte
//   din_valid    din holds a valid byte
//   din_ready    transmitter byte buffer can accept (transfer on valid && ready)
//   signal       serial frame bit, MSB first per field
//   signal_valid signal carries a frame bit
//   busy         frame or inter-frame gap in progress
//   done         one-cycle pulse on successful frame completion
//   err          one-cycle pulse on a rejected start or payload underrun
//
// master: frame source (drives request and payload). slave: the transmitter.
interface eth_frame_tx_if;
    logic        start;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] length;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        signal;
    logic        signal_valid;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, dest_mac, src_mac, length, din, din_valid,
        input  din_ready, signal, signal_valid, busy, done, err
    );

    modport slave (
        input  start, dest_mac, src_mac, length, din, din_valid,
        output din_ready, signal, signal_valid, busy, done, err
    );
endinterface

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: serial Ethernet frame transmitter, one bit per clock.
// Emits preamble (56 bits 1010..), SFD (10101011), destination MAC, source MAC,
// length, payload and a CRC-32 FCS, every field MSB first. The CRC covers
// DST..payload (init 0, no reflection, no final XOR), so DST..FCS is exactly
// divisible by POLY.
//
// Ports:
//   clk  single clock, posedge
//   rst  synchronous active-high reset; clears state, buffer, counters, CRC
//   tx   eth_frame_tx_if.slave: request fields, payload stream, serial outputs
//
// Parameters: MAX_LEN (max payload bytes), POLY (CRC-32 polynomial, x^32
// implicit), IFG_BITS (inter-frame gap clocks).
//
// Build option: define ETH_TX_IFG_EN to add an inter-frame gap of IFG_BITS
// clocks (busy high, signal idle) after each completed frame. Without it,
// busy falls with the done pulse and back-to-back frames are possible.
module eth_frame_tx #(
    parameter int unsigned MAX_LEN  = 1500,
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter int unsigned IFG_BITS = 96
) (
    input logic           clk,
    input logic           rst,
    eth_frame_tx_if.slave tx
);
    // One counter serves every field, the payload and (optionally) the gap.
    localparam int unsigned PayBits = MAX_LEN * 8;
    localparam int unsigned CntMax  = (PayBits > IFG_BITS) ? PayBits : IFG_BITS;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    // state_q/cnt_q name the bit that the next edge places on signal.
    typedef enum logic [3:0] {
        StIdle, StPre, StSfd, StDst, StSrc, StLen, StPay, StFcs, StIfg
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [111:0]    hdr_q, hdr_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     fetched_q, fetched_d;
    logic [7:0]      byte_q, byte_d;
    logic            full_q, full_d;
    logic [7:0]      sh_q, sh_d;
    logic [31:0]     crc_q, crc_d;
    logic            sig_q, sig_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic din_ready;
    logic hdr_state;
    logic hdr_last;
    logic pay_last;
    logic start_bad;
    logic pay_bit;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'd0);
    endfunction

    assign hdr_state = (state_q == StDst) || (state_q == StSrc) || (state_q == StLen);
    assign hdr_last  = (state_q == StLen) ? (cnt_q == CntW'(15)) : (cnt_q == CntW'(47));
    assign pay_last  = 32'(cnt_q) == ({13'd0, len_q, 3'b000} - 32'd1);
    assign start_bad = (tx.length == 16'd0) || (32'(tx.length) > MAX_LEN);

    // Prefetch of the first byte happens during the header.
    assign din_ready = !full_q && (fetched_q < len_q) && (hdr_state || state_q == StPay);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        hdr_d     = hdr_q;
        len_d     = len_q;
        fetched_d = fetched_q;
        byte_d    = byte_q;
        full_d    = full_q;
        sh_d      = sh_q;
        crc_d     = crc_q;
        sig_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pay_bit   = 1'b0;

        if (tx.din_valid && din_ready) begin
            byte_d    = tx.din;
            full_d    = 1'b1;
            fetched_d = fetched_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (tx.start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        // First preamble bit goes out on this edge.
                        state_d   = StPre;
                        cnt_d     = CntW'(1);
                        sig_d     = 1'b1;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        hdr_d     = {tx.dest_mac, tx.src_mac, tx.length};
                        len_d     = tx.length;
                        crc_d     = '0;
                        full_d    = 1'b0;
                        fetched_d = '0;
                    end
                end
            end
            StPre: begin
                sig_d   = ~cnt_q[0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (cnt_q == CntW'(55)) begin
                    state_d = StSfd;
                    cnt_d   = '0;
                end
            end
            StSfd: begin
                sig_d   = (cnt_q == CntW'(7)) ? 1'b1 : ~cnt_q[0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (cnt_q == CntW'(7)) begin
                    state_d = StDst;
                    cnt_d   = '0;
                end
            end
            StDst, StSrc, StLen: begin
                sig_d   = hdr_q[111];
                hdr_d   = {hdr_q[110:0], 1'b0};
                crc_d   = crc_step(crc_q, hdr_q[111]);
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (hdr_last) begin
                    cnt_d = '0;
                    if (state_q == StDst) begin
                        state_d = StSrc;
                    end else if (state_q == StSrc) begin
                        state_d = StLen;
                    end else begin
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                if (cnt_q[2:0] == 3'd0 && !full_q) begin
                    // Underrun: abort with the line idle from this cycle on.
                    state_d = StIdle;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    if (cnt_q[2:0] == 3'd0) begin
                        pay_bit = byte_q[7];
                        sh_d    = {byte_q[6:0], 1'b0};
                        full_d  = 1'b0;
                    end else begin
                        pay_bit = sh_q[7];
                        sh_d    = {sh_q[6:0], 1'b0};
                    end
                    sig_d   = pay_bit;
                    crc_d   = crc_step(crc_q, pay_bit);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    if (pay_last) begin
                        state_d = StFcs;
                        cnt_d   = '0;
                    end
                end
            end
            StFcs: begin
                // cnt 32 is the cycle the last FCS bit is on the line; the
                // next edge ends the frame so start is not sampled too early.
                if (cnt_q == CntW'(32)) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
`ifdef ETH_TX_IFG_EN
                    state_d = StIfg;
                    busy_d  = 1'b1;
`else
                    state_d = StIdle;
`endif
                end else begin
                    sig_d   = crc_q[31];
                    crc_d   = {crc_q[30:0], 1'b0};
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
`ifdef ETH_TX_IFG_EN
            StIfg: begin
                if (cnt_q == CntW'(IFG_BITS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    busy_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hdr_q     <= '0;
            len_q     <= '0;
            fetched_q <= '0;
            byte_q    <= '0;
            full_q    <= 1'b0;
            sh_q      <= '0;
            crc_q     <= '0;
            sig_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            len_q     <= len_d;
            fetched_q <= fetched_d;
            byte_q    <= byte_d;
            full_q    <= full_d;
            sh_q      <= sh_d;
            crc_q     <= crc_d;
            sig_q     <= sig_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx.din_ready    = din_ready;
    assign tx.signal       = sig_q;
    assign tx.signal_valid = valid_q;
    assign tx.busy         = busy_q;
    assign tx.done         = done_q;
    assign tx.err          = err_q;
endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed testbench for eth_frame_tx: frame layout and FCS against a
// long-division model, timing of first bit / done, underrun, start rejection,
// reset mid-payload and back-to-back frames.
module tb_eth_frame_tx;
`ifdef ETH_TX_IFG_EN
    localparam int   B2bFirst = 314;
    localparam logic DoneBusy = 1'b1;
`else
    localparam int   B2bFirst = 218;
    localparam logic DoneBusy = 1'b0;
`endif
    localparam logic [31:0] Poly = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rst;
    eth_frame_tx_if bus ();

    eth_frame_tx #(
        .MAX_LEN (1500),
        .POLY    (Poly),
        .IFG_BITS(96)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic       cap  [0:1023];
    logic       expb [0:1023];
    logic       work [0:1023];
    logic [7:0] pay  [0:15];
    int n_cap, n_exp;
    int first_cyc, done_cyc, err_cyc, cyc;
    logic [31:0] fcs_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Textbook polynomial long division over work[0..n-1]; remainder is the last 32 bits.
    task automatic divide(input int n, output logic [31:0] rem);
        logic [32:0] g;
        g = {1'b1, Poly};
        for (int i = 0; i <= n - 33; i++) begin
            if (work[i]) begin
                for (int j = 0; j < 33; j++) work[i+j] = work[i+j] ^ g[32-j];
            end
        end
        for (int k = 0; k < 32; k++) rem[31-k] = work[n-32+k];
    endtask

    task automatic build_exp(input logic [47:0] d, input logic [47:0] s, input logic [15:0] len);
        logic [7:0]   sfd;
        logic [111:0] hdr;
        int m;
        sfd = 8'hAB;
        hdr = {d, s, len};
        n_exp = 0;
        for (int i = 0; i < 56; i++) begin expb[n_exp] = (i % 2 == 0); n_exp++; end
        for (int i = 7; i >= 0; i--) begin expb[n_exp] = sfd[i]; n_exp++; end
        for (int i = 111; i >= 0; i--) begin expb[n_exp] = hdr[i]; n_exp++; end
        for (int b = 0; b < int'(len); b++)
            for (int i = 7; i >= 0; i--) begin expb[n_exp] = pay[b][i]; n_exp++; end
        m = n_exp - 64;
        for (int i = 0; i < m; i++) work[i] = expb[64+i];
        for (int i = 0; i < 32; i++) work[m+i] = 1'b0;
        divide(m + 32, fcs_model);
        for (int i = 31; i >= 0; i--) begin expb[n_exp] = fcs_model[i]; n_exp++; end
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 300 && bus.busy; k++) tick;
        check("idle before start", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] len,
                             input int n_avail, input logic hold, input int budget);
        int   idx;
        logic xfer;
        bus.dest_mac  = d;
        bus.src_mac   = s;
        bus.length    = len;
        bus.start     = 1'b1;
        bus.din       = pay[0];
        bus.din_valid = (n_avail > 0);
        idx = 0; n_cap = 0; cyc = 0;
        first_cyc = -1; done_cyc = -1; err_cyc = -1;
        while (cyc < budget && done_cyc < 0 && err_cyc < 0) begin
            xfer = bus.din_valid && bus.din_ready;
            tick;
            cyc++;
            bus.start = hold;
            if (xfer) begin
                idx++;
                bus.din       = pay[idx[3:0]];
                bus.din_valid = (idx < n_avail);
            end
            if (bus.signal_valid && n_cap < 1024) begin
                if (first_cyc < 0) first_cyc = cyc;
                cap[n_cap] = bus.signal;
                n_cap++;
            end
            if (bus.done) done_cyc = cyc;
            if (bus.err) err_cyc = cyc;
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int len);
        int n, nm, m;
        logic [31:0] fcs_cap, rem;
        n = 208 + 8 * len;
        check({tag, " first bit cycle"}, 64'(first_cyc), 64'(1));
        check({tag, " done cycle"}, 64'(done_cyc), 64'(n + 1));
        check({tag, " bit count"}, 64'(n_cap), 64'(n));
        check({tag, " done cycle valid/busy"}, {62'd0, bus.signal_valid, bus.busy},
              {62'd0, 1'b0, DoneBusy});
        nm = 0;
        for (int i = 0; i < n_exp && i < n_cap; i++) if (cap[i] !== expb[i]) nm++;
        check({tag, " frame bit mismatches"}, 64'(nm), 64'd0);
        fcs_cap = '0;
        if (n_cap >= n) for (int i = 0; i < 32; i++) fcs_cap[31-i] = cap[n-32+i];
        check({tag, " fcs"}, {32'd0, fcs_cap}, {32'd0, fcs_model});
        rem = 32'hFFFF_FFFF;
        if (n_cap >= 96) begin
            m = n_cap - 64;
            for (int i = 0; i < m; i++) work[i] = cap[64+i];
            divide(m, rem);
        end
        check({tag, " dst..fcs mod poly"}, {32'd0, rem}, 64'd0);
        tick;
        check({tag, " done one cycle"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin : stim
        logic [63:0] pre;
        logic [7:0]  pb;
        rst = 1'b1;
        bus.start = 1'b0; bus.dest_mac = '0; bus.src_mac = '0; bus.length = '0;
        bus.din = '0; bus.din_valid = 1'b0;
        for (int i = 0; i < 16; i++) pay[i] = 8'h00;
        tick; tick;
        check("reset outputs", {58'd0, bus.signal, bus.signal_valid, bus.busy, bus.done,
              bus.err, bus.din_ready}, 64'd0);
        rst = 1'b0;
        tick;

        // length=1, payload A5, MACs zero.
        pay[0] = 8'hA5;
        build_exp(48'd0, 48'd0, 16'd1);
        run_frame(48'd0, 48'd0, 16'd1, 1, 1'b0, 400);
        pre = '0;
        for (int i = 0; i < 64; i++) pre[63-i] = cap[i];
        check("preamble+sfd", pre, 64'hAAAA_AAAA_AAAA_AAAB);
        pb = '0;
        for (int i = 0; i < 8; i++) pb[7-i] = cap[176+i];
        check("len1 payload byte", {56'd0, pb}, {56'd0, 8'hA5});
        check_frame("len1", 1);

        // length=4, everything else zero.
        wait_idle;
        for (int i = 0; i < 4; i++) pay[i] = 8'h00;
        build_exp(48'd0, 48'd0, 16'd4);
        run_frame(48'd0, 48'd0, 16'd4, 4, 1'b0, 400);
        check_frame("len4 zero", 4);

        // Underrun: length=3, only two bytes supplied.
        wait_idle;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_frame(48'h1, 48'h2, 16'd3, 2, 1'b0, 400);
        check("underrun err cycle", 64'(err_cyc), 64'(193));
        check("underrun no done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        check("underrun bits sent", 64'(n_cap), 64'(192));
        check("underrun line idle", {62'd0, bus.signal_valid, bus.signal}, 64'd0);
        tick;
        check("underrun after", {61'd0, bus.busy, bus.err, bus.done}, 64'd0);

        // Start rejection.
        bus.start = 1'b1; bus.length = 16'd0;
        tick;
        check("len0 reject", {61'd0, bus.err, bus.busy, bus.signal_valid}, {61'd0, 3'b100});
        bus.length = 16'd1501;
        tick;
        check("len1501 reject", {61'd0, bus.err, bus.busy, bus.signal_valid}, {61'd0, 3'b100});
        bus.start = 1'b0;
        tick;
        check("reject pulse ends", {62'd0, bus.err, bus.busy}, 64'd0);

        // Reset mid-payload, then a clean frame.
        for (int i = 0; i < 4; i++) pay[i] = 8'h5A;
        run_frame(48'h1, 48'h2, 16'd4, 4, 1'b0, 185);
        rst = 1'b1;
        tick;
        check("outputs after mid-pay reset", {58'd0, bus.signal, bus.signal_valid, bus.busy,
              bus.done, bus.err, bus.din_ready}, 64'd0);
        rst = 1'b0;
        tick;
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        build_exp(48'h0123_4567_89AB, 48'hCAFE_F00D_1234, 16'd4);
        run_frame(48'h0123_4567_89AB, 48'hCAFE_F00D_1234, 16'd4, 4, 1'b0, 400);
        check_frame("after reset", 4);

        // Back-to-back with start held high.
        wait_idle;
        pay[0] = 8'hA5;
        build_exp(48'd0, 48'd0, 16'd1);
        run_frame(48'd0, 48'd0, 16'd1, 1, 1'b1, 400);
        check("b2b first done cycle", 64'(done_cyc), 64'(217));
        for (int k = 0; k < 200 && !bus.signal_valid; k++) begin
            tick;
            cyc++;
        end
        check("b2b second frame first bit", 64'(cyc), 64'(B2bFirst));
        bus.start = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
